regfile_mp: RTL

Parametrised multi-port integer register file for the next-generation core: configurable data width, register count and read-port count, two write ports, same-cycle write-to-read bypass, and a per-register busy scoreboard for pipelined issue. It replaces the single-write, two-read register file between decode (reads, issue) and writeback (writes). Register 0 is hardwired to zero.

---
 rtl/regfile_mp.sv | 114 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, NRD bypassed read ports,
// and a per-register busy scoreboard for pipelined issue. x0 reads as zero.

module regfile_mp_rd #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic                      reset,
  input  logic [AW-1:0]             addr,
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [NREG-1:0]           busy,
  input  logic                      we0,
  input  logic [AW-1:0]             wa0,
  input  logic [XLEN-1:0]           wd0,
  input  logic                      we1,
  input  logic [AW-1:0]             wa1,
  input  logic [XLEN-1:0]           wd1,
  input  logic                      clr0,
  input  logic                      clr1,
  output logic [XLEN-1:0]           data,
  output logic                      busy_o
);
  logic live;
  assign live = !reset && (addr != '0);

  // Port 1 bypass outranks port 0, matching the write-collision winner.
  always_comb begin
    data = '0;
    if (live) begin
      if (we1 && wa1 == addr)      data = wd1;
      else if (we0 && wa0 == addr) data = wd0;
      else                         data = regs[addr];
    end
  end

  // Same-cycle clears are bypassed; same-cycle sets only show after the edge.
  always_comb begin
    busy_o = 1'b0;
    if (live && !(clr0 && wa0 == addr) && !(clr1 && wa1 == addr))
      busy_o = busy[addr];
  end
endmodule

module regfile_mp #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       wa0,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd0,
  input  logic [XLEN-1:0]     wd1,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                wb_clr0,
  input  logic                wb_clr1
);
  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0]           busy_q, busy_d;

  always_comb begin
    regs_d = regs_q;
    if (we0) regs_d[wa0] = wd0;
    if (we1) regs_d[wa1] = wd1;
    regs_d[0] = '0;
  end

  // Issue is applied after the clears so a new producer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_clr0)   busy_d[wa0]    = 1'b0;
    if (wb_clr1)   busy_d[wa1]    = 1'b0;
    if (iss_valid) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_mp_rd #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rd (
      .reset (reset),
      .addr  (rs_addr[k*AW +: AW]),
      .regs  (regs_q),
      .busy  (busy_q),
      .we0   (we0),
      .wa0   (wa0),
      .wd0   (wd0),
      .we1   (we1),
      .wa1   (wa1),
      .wd1   (wd1),
      .clr0  (wb_clr0),
      .clr1  (wb_clr1),
      .data  (rs_data[k*XLEN +: XLEN]),
      .busy_o(rs_busy[k])
    );
  end
endmodule
